// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: scans FFT bins BIN_LO..BIN_HI for the largest |X|^2 and reports
// bin, magnitude, frequency in Hz and peak stability. Optional feature: MAG_GATE_EN.
module fft_peak_tracker #(
    parameter int BIT_WIDTH     = 16,
    parameter int N             = 9,
    parameter int FFT_SIZE      = 512,
    parameter int FS            = 48000,
    parameter int BIN_LO        = 2,
    parameter int BIN_HI        = 255,
    parameter int STABLE_FRAMES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_done,
    output logic [N-1:0]           rd_addr,
    input  logic [2*BIT_WIDTH-1:0] rd_data,
    output logic                   rd_busy,
    input  logic [2*BIT_WIDTH-1:0] mag_thresh,
    output logic                   peak_valid,
    output logic [N-1:0]           peak_bin,
    output logic [2*BIT_WIDTH-1:0] peak_mag,
    output logic [BIT_WIDTH:0]     frequency,
    output logic                   note_stable
);

    localparam int HALF    = FFT_SIZE / 2;
    localparam int BIN_TOP = (BIN_HI < HALF) ? BIN_HI : HALF - 1;
    localparam int MW      = 2 * BIT_WIDTH;
    localparam int PW      = N + 17;
    localparam int CW      = $clog2(STABLE_FRAMES + 1);

    localparam logic [N-1:0]  LO_ADDR    = N'(BIN_LO);
    localparam logic [N-1:0]  HI_ADDR    = N'(BIN_TOP);
    localparam logic [PW-1:0] FS_W       = PW'(FS);
    localparam logic [CW-1:0] STABLE_CNT = CW'(STABLE_FRAMES);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        CALC,
        REPORT
    } state_t;

    state_t state, next_state;

    logic                        drain_cnt;
    logic                        v1, v2;
    logic [N-1:0]                bin1, bin2;
    logic [MW-1:0]               mag2;
    logic [MW-1:0]               max_mag;
    logic [N-1:0]                max_bin;
    logic [CW-1:0]               stab_cnt;

    logic signed [BIT_WIDTH-1:0] re_s, im_s;
    logic signed [MW-1:0]        re_x, im_x;
    logic [MW-1:0]               mag_c;
    logic [PW-1:0]               prod;
    logic [BIT_WIDTH:0]          freq_c;
    logic [N-1:0]                bin_diff;
    logic [CW-1:0]               stab_next;
    logic                        silent;

    // Squares of sign-extended components are non-negative, so the sum fits MW bits.
    assign re_s  = rd_data[MW-1:BIT_WIDTH];
    assign im_s  = rd_data[BIT_WIDTH-1:0];
    assign re_x  = MW'(re_s);
    assign im_x  = MW'(im_s);
    assign mag_c = re_x * re_x + im_x * im_x;

    assign prod   = PW'(max_bin) * FS_W;
    assign freq_c = (BIT_WIDTH + 1)'(prod >> N);

    assign bin_diff = (max_bin > peak_bin) ? max_bin - peak_bin
                                           : peak_bin - max_bin;

    always_comb begin
        stab_next = CW'(1);
        if (bin_diff <= N'(1)) begin
            stab_next = (stab_cnt == STABLE_CNT) ? stab_cnt
                                                 : stab_cnt + CW'(1);
        end
    end

`ifdef MAG_GATE_EN
    assign silent = (max_mag <= mag_thresh);
`else
    logic unused_thresh;
    assign unused_thresh = ^mag_thresh;
    assign silent        = 1'b0;
`endif

    assign rd_busy = (state == SCAN) || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (fft_done) next_state = SCAN;
            SCAN:    if (rd_addr == HI_ADDR) next_state = DRAIN;
            DRAIN:   if (drain_cnt) next_state = CALC;
            CALC:    next_state = REPORT;
            REPORT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr     <= '0;
            drain_cnt   <= 1'b0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            bin1        <= '0;
            bin2        <= '0;
            mag2        <= '0;
            max_mag     <= '0;
            max_bin     <= '0;
            stab_cnt    <= '0;
            peak_valid  <= 1'b0;
            peak_bin    <= '0;
            peak_mag    <= '0;
            frequency   <= '0;
            note_stable <= 1'b0;
        end else begin
            v1         <= (state == SCAN);
            bin1       <= rd_addr;
            v2         <= v1;
            bin2       <= bin1;
            mag2       <= mag_c;
            drain_cnt  <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            peak_valid <= 1'b0;

            // Strictly greater keeps the lowest bin on ties.
            if (v2 && (mag2 > max_mag)) begin
                max_mag <= mag2;
                max_bin <= bin2;
            end

            unique case (state)
                IDLE: begin
                    if (fft_done) begin
                        rd_addr <= LO_ADDR;
                        max_mag <= '0;
                        max_bin <= LO_ADDR;
                    end
                end
                SCAN: begin
                    if (rd_addr != HI_ADDR) rd_addr <= rd_addr + N'(1);
                end
                CALC: begin
                    peak_valid <= 1'b1;
                    peak_mag   <= max_mag;
                    if (silent) begin
                        peak_bin    <= '0;
                        frequency   <= '0;
                        stab_cnt    <= '0;
                        note_stable <= 1'b0;
                    end else begin
                        peak_bin    <= max_bin;
                        frequency   <= freq_c;
                        stab_cnt    <= stab_next;
                        note_stable <= (stab_next == STABLE_CNT);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
